sparc_ifu_wselpipe: RTL and testbench



---
 rtl/sparc_ifu_wselpipe.sv | 177 +++++++++++++++++
 tb/tb_sparc_ifu_wselpipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sparc_ifu_wselpipe.sv
// rtl/sparc_ifu_wselpipe.sv - icache way-select datapath with ASI/mbist read port and way-select mutex checker
//
// Purpose:
//   Selects one icache way (fetch and top halves) with the ITLB way-select
//   using a flat AND-OR structure. Serves ASI/mbist way reads through a
//   request/valid/ack handshake backed by a holding register. Watches the
//   way-select for more than one bit set and counts violations.
//
// Optional feature macro: IFU_WSEL_OUTREG_EN
//   defined   : fetch/top outputs are registered (1 cycle latency, reset to 0)
//   undefined : fetch/top outputs are combinational (0 cycle latency)
//
// Ports:
//   rclk, rst_l                  clock, synchronous active-low reset
//   icd_wsel_fetdata_s1          NWAYS fetch words, way k at [k*WAY_W +: WAY_W]
//   icd_wsel_topdata_s1          NWAYS top words, same packing
//   itlb_wsel_waysel_s1          way select, one-hot or zero
//   wsel_fdp_fetdata_s1          selected fetch word
//   wsel_fdp_topdata_s1          selected top word
//   ifq_wsel_asird_vld/_way      ASI read request and way index
//   wsel_ifq_asird_rdy           request can be accepted
//   wsel_ifq_asidata_vld         held ASI data valid
//   ifq_wsel_asidata_ack         consumer takes held data
//   wsel_mbist_icache_data       held ASI data {T[W-1:W-2],F[W-1:W-2],T[W-3:0],F[W-3:0]}
//   wsel_ifq_waysel_err          one-cycle pulse per way-select violation
//   wsel_waysel_errcnt           saturating violation count
//   ifq_wsel_errcnt_clr          clear violation count

module sparc_ifu_wselpipe #(
    parameter int NWAYS    = 4,
    parameter int WAY_W    = 34,
    parameter int WAYIDX_W = 2,
    parameter int ERRCNT_W = 8
) (
    input  logic                    rclk,
    input  logic                    rst_l,
    input  logic [NWAYS*WAY_W-1:0]  icd_wsel_fetdata_s1,
    input  logic [NWAYS*WAY_W-1:0]  icd_wsel_topdata_s1,
    input  logic [NWAYS-1:0]        itlb_wsel_waysel_s1,
    output logic [WAY_W-1:0]        wsel_fdp_fetdata_s1,
    output logic [WAY_W-1:0]        wsel_fdp_topdata_s1,
    input  logic                    ifq_wsel_asird_vld,
    input  logic [WAYIDX_W-1:0]     ifq_wsel_asird_way,
    output logic                    wsel_ifq_asird_rdy,
    output logic                    wsel_ifq_asidata_vld,
    input  logic                    ifq_wsel_asidata_ack,
    output logic [2*WAY_W-1:0]      wsel_mbist_icache_data,
    output logic                    wsel_ifq_waysel_err,
    output logic [ERRCNT_W-1:0]     wsel_waysel_errcnt,
    input  logic                    ifq_wsel_errcnt_clr
);

    // ------------------------------------------------------------------
    // Fetch path way select: AND-OR, multiple set bits OR their ways.
    // ------------------------------------------------------------------
    logic [WAY_W-1:0] sel_fet;
    logic [WAY_W-1:0] sel_top;

    always_comb begin
        sel_fet = '0;
        sel_top = '0;
        for (int k = 0; k < NWAYS; k++) begin
            sel_fet = sel_fet | (icd_wsel_fetdata_s1[k*WAY_W +: WAY_W] & {WAY_W{itlb_wsel_waysel_s1[k]}});
            sel_top = sel_top | (icd_wsel_topdata_s1[k*WAY_W +: WAY_W] & {WAY_W{itlb_wsel_waysel_s1[k]}});
        end
    end

`ifdef IFU_WSEL_OUTREG_EN
    logic [WAY_W-1:0] fet_q;
    logic [WAY_W-1:0] top_q;

    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            fet_q <= '0;
            top_q <= '0;
        end else begin
            fet_q <= sel_fet;
            top_q <= sel_top;
        end
    end

    assign wsel_fdp_fetdata_s1 = fet_q;
    assign wsel_fdp_topdata_s1 = top_q;
`else
    assign wsel_fdp_fetdata_s1 = sel_fet;
    assign wsel_fdp_topdata_s1 = sel_top;
`endif

    // ------------------------------------------------------------------
    // ASI / mbist read handshake
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ASI_IDLE = 2'd0,
        ASI_SAMP = 2'd1,
        ASI_HOLD = 2'd2
    } asi_state_t;

    asi_state_t             asi_state_q;
    asi_state_t             asi_state_d;
    logic [WAYIDX_W-1:0]    asi_way_q;
    logic [2*WAY_W-1:0]     asi_data_q;
    logic [WAY_W-1:0]       asi_fet;
    logic [WAY_W-1:0]       asi_top;

    // Way index decode; an index with no matching way leaves the word zero.
    always_comb begin
        asi_fet = '0;
        asi_top = '0;
        for (int k = 0; k < NWAYS; k++) begin
            if (asi_way_q == WAYIDX_W'(k)) begin
                asi_fet = icd_wsel_fetdata_s1[k*WAY_W +: WAY_W];
                asi_top = icd_wsel_topdata_s1[k*WAY_W +: WAY_W];
            end
        end
    end

    always_comb begin
        asi_state_d = asi_state_q;
        case (asi_state_q)
            ASI_IDLE: if (ifq_wsel_asird_vld)   asi_state_d = ASI_SAMP;
            ASI_SAMP:                           asi_state_d = ASI_HOLD;
            ASI_HOLD: if (ifq_wsel_asidata_ack) asi_state_d = ASI_IDLE;
            default:                            asi_state_d = ASI_IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            asi_state_q <= ASI_IDLE;
            asi_way_q   <= '0;
            asi_data_q  <= '0;
        end else begin
            asi_state_q <= asi_state_d;
            if (asi_state_q == ASI_IDLE && ifq_wsel_asird_vld) begin
                asi_way_q <= ifq_wsel_asird_way;
            end
            if (asi_state_q == ASI_SAMP) begin
                // Parity/predecode bits of both halves sit above the data words.
                asi_data_q <= {asi_top[WAY_W-1 -: 2], asi_fet[WAY_W-1 -: 2],
                               asi_top[WAY_W-3:0],    asi_fet[WAY_W-3:0]};
            end
        end
    end

    // Ready is gated with rst_l so it reads low for the whole reset window.
    assign wsel_ifq_asird_rdy     = (asi_state_q == ASI_IDLE) && rst_l;
    assign wsel_ifq_asidata_vld   = (asi_state_q == ASI_HOLD);
    assign wsel_mbist_icache_data = asi_data_q;

    // ------------------------------------------------------------------
    // Way-select mutex checker
    // ------------------------------------------------------------------
    logic                   viol;
    logic                   err_q;
    logic [ERRCNT_W-1:0]    errcnt_q;

    // x & (x-1) clears the lowest set bit; anything left means 2+ bits set.
    assign viol = |(itlb_wsel_waysel_s1 & (itlb_wsel_waysel_s1 - NWAYS'(1)));

    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            err_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            err_q <= viol;
            if (ifq_wsel_errcnt_clr) begin
                errcnt_q <= viol ? ERRCNT_W'(1) : '0;
            end else if (viol && !(&errcnt_q)) begin
                errcnt_q <= errcnt_q + ERRCNT_W'(1);
            end
        end
    end

    assign wsel_ifq_waysel_err = err_q;
    assign wsel_waysel_errcnt  = errcnt_q;

endmodule

// File: tb/tb_sparc_ifu_wselpipe.sv
// tb/tb_sparc_ifu_wselpipe.sv - scoreboard bench for sparc_ifu_wselpipe (4-way and 3-way/2-bit-counter instances)
module tb_sparc_ifu_wselpipe;

    localparam int W = 34;

    logic clk = 1'b0;
    logic rst_l;

    // Instance 0: NWAYS=4, ERRCNT_W=8
    logic [4*W-1:0] fet0, top0;
    logic [3:0]     ws0;
    logic [W-1:0]   ofet0, otop0;
    logic           av0, rdy0, dv0, ack0, err0, clr0;
    logic [1:0]     aw0;
    logic [2*W-1:0] md0;
    logic [7:0]     cnt0;

    // Instance 1: NWAYS=3, ERRCNT_W=2
    logic [3*W-1:0] fet1, top1;
    logic [2:0]     ws1;
    logic [W-1:0]   ofet1, otop1;
    logic           av1, rdy1, dv1, ack1, err1, clr1;
    logic [1:0]     aw1;
    logic [2*W-1:0] md1;
    logic [1:0]     cnt1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [2*W-1:0] q0[$];
    logic [2*W-1:0] q1[$];

    sparc_ifu_wselpipe #(.NWAYS(4), .WAY_W(W), .WAYIDX_W(2), .ERRCNT_W(8)) u_dut0 (
        .rclk(clk), .rst_l(rst_l),
        .icd_wsel_fetdata_s1(fet0), .icd_wsel_topdata_s1(top0),
        .itlb_wsel_waysel_s1(ws0),
        .wsel_fdp_fetdata_s1(ofet0), .wsel_fdp_topdata_s1(otop0),
        .ifq_wsel_asird_vld(av0), .ifq_wsel_asird_way(aw0),
        .wsel_ifq_asird_rdy(rdy0), .wsel_ifq_asidata_vld(dv0),
        .ifq_wsel_asidata_ack(ack0), .wsel_mbist_icache_data(md0),
        .wsel_ifq_waysel_err(err0), .wsel_waysel_errcnt(cnt0),
        .ifq_wsel_errcnt_clr(clr0)
    );

    sparc_ifu_wselpipe #(.NWAYS(3), .WAY_W(W), .WAYIDX_W(2), .ERRCNT_W(2)) u_dut1 (
        .rclk(clk), .rst_l(rst_l),
        .icd_wsel_fetdata_s1(fet1), .icd_wsel_topdata_s1(top1),
        .itlb_wsel_waysel_s1(ws1),
        .wsel_fdp_fetdata_s1(ofet1), .wsel_fdp_topdata_s1(otop1),
        .ifq_wsel_asird_vld(av1), .ifq_wsel_asird_way(aw1),
        .wsel_ifq_asird_rdy(rdy1), .wsel_ifq_asidata_vld(dv1),
        .ifq_wsel_asidata_ack(ack1), .wsel_mbist_icache_data(md1),
        .wsel_ifq_waysel_err(err1), .wsel_waysel_errcnt(cnt1),
        .ifq_wsel_errcnt_clr(clr1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the expected ASI word whenever the consumer takes data.
    always @(negedge clk) begin
        if (dv0 === 1'b1 && ack0 === 1'b1) begin
            if (q0.size() == 0) chk("asi0_unexpected", md0, '0 ^ {2*W{1'bx}});
            else chk("asi0_data", md0, q0.pop_front());
        end
        if (dv1 === 1'b1 && ack1 === 1'b1) begin
            if (q1.size() == 0) chk("asi1_unexpected", md1, '0 ^ {2*W{1'bx}});
            else chk("asi1_data", md1, q1.pop_front());
        end
    end

    task automatic sel_chk(input string name, input logic [3:0] ws,
                           input logic [W-1:0] ef, input logic [W-1:0] et);
        ws0 = ws;
`ifdef IFU_WSEL_OUTREG_EN
        @(posedge clk);
`endif
        @(negedge clk);
        chk({name, "_fet"}, 68'(ofet0), 68'(ef));
        chk({name, "_top"}, 68'(otop0), 68'(et));
    endtask

    // One ASI read: request, data present only in the sample cycle, hold, ack.
    task automatic asi_txn(input int d, input int way, input logic [W-1:0] f,
                           input logic [W-1:0] t, input logic [2*W-1:0] exp, input int hold);
        logic [W-1:0] g;
        g = 34'h2_DEAD_BEEF;
        @(negedge clk);
        chk($sformatf("asi%0d_rdy_idle", d), 68'(d == 0 ? rdy0 : rdy1), 68'(1));
        tick();
        if (d == 0) begin av0 = 1'b1; aw0 = 2'(way); q0.push_back(exp); end
        else        begin av1 = 1'b1; aw1 = 2'(way); q1.push_back(exp); end
        tick();
        av0 = 1'b0; av1 = 1'b0;
        if (d == 0) begin
            for (int k = 0; k < 4; k++) begin fet0[k*W +: W] = g; top0[k*W +: W] = ~g; end
            if (way < 4) begin fet0[way*W +: W] = f; top0[way*W +: W] = t; end
        end else begin
            for (int k = 0; k < 3; k++) begin
                fet1[k*W +: W] = (way < 3) ? g : f;
                top1[k*W +: W] = (way < 3) ? ~g : t;
            end
            if (way < 3) begin fet1[way*W +: W] = f; top1[way*W +: W] = t; end
        end
        @(negedge clk);
        chk($sformatf("asi%0d_rdy_samp", d), 68'(d == 0 ? rdy0 : rdy1), 68'(0));
        tick();
        fet0 = {4{34'h0_5A5A_A5A5}}; top0 = {4{34'h1_C3C3_3C3C}};
        fet1 = {3{34'h0_5A5A_A5A5}}; top1 = {3{34'h1_C3C3_3C3C}};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk($sformatf("asi%0d_vld_hold", d), 68'(d == 0 ? dv0 : dv1), 68'(1));
            chk($sformatf("asi%0d_stable", d), d == 0 ? md0 : md1, exp);
            tick();
        end
        if (d == 0) ack0 = 1'b1; else ack1 = 1'b1;
        tick();
        ack0 = 1'b0; ack1 = 1'b0;
        @(negedge clk);
        chk($sformatf("asi%0d_rdy_after", d), 68'(d == 0 ? rdy0 : rdy1), 68'(1));
        chk($sformatf("asi%0d_vld_after", d), 68'(d == 0 ? dv0 : dv1), 68'(0));
    endtask

    initial begin
        rst_l = 1'b0;
        fet0 = '0; top0 = '0; ws0 = '0; av0 = 1'b0; aw0 = '0; ack0 = 1'b0; clr0 = 1'b0;
        fet1 = '0; top1 = '0; ws1 = '0; av1 = 1'b0; aw1 = '0; ack1 = 1'b0; clr1 = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_rdy", 68'(rdy0), 68'(0));
        chk("rst_vld", 68'(dv0), 68'(0));
        chk("rst_data", md0, '0);
        chk("rst_err", 68'(err0), 68'(0));
        chk("rst_cnt", 68'(cnt0), 68'(0));
        tick();
        rst_l = 1'b1;
        @(negedge clk);
        chk("rel_rdy0", 68'(rdy0), 68'(1));
        chk("rel_rdy1", 68'(rdy1), 68'(1));

        // Way select on instance 0
        fet0 = {34'h3_F000_0000, 34'h2_AAAA_5555, 34'h1_0F0F_0000, 34'h0_0000_000F};
        top0 = {34'h2_0000_00F0, 34'h1_0000_ABCD, 34'h0_1234_0000, 34'h3_0000_0001};
        sel_chk("sel_w2", 4'b0100, 34'h2_AAAA_5555, 34'h1_0000_ABCD);
        sel_chk("sel_w0", 4'b0001, 34'h0_0000_000F, 34'h3_0000_0001);
        sel_chk("sel_none", 4'b0000, 34'h0, 34'h0);
        sel_chk("sel_or12", 4'b0110, 34'h3_AFAF_5555, 34'h1_1234_ABCD);
        ws0 = 4'b0000;
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        tick();

        // Mutex checker: three violating cycles
        ws0 = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) ws0 = 4'b0000;
            @(negedge clk);
            chk("mutex_err", 68'(err0), 68'(1));
        end
        tick();
        @(negedge clk);
        chk("mutex_err_off", 68'(err0), 68'(0));
        chk("mutex_cnt3", 68'(cnt0), 68'(3));
        tick();
        ws0 = 4'b0110; clr0 = 1'b1;
        tick();
        ws0 = 4'b0000; clr0 = 1'b0;
        @(negedge clk);
        chk("mutex_clr_viol", 68'(cnt0), 68'(1));
        tick();
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        @(negedge clk);
        chk("mutex_clr", 68'(cnt0), 68'(0));
        tick();

        // Saturation on the 2-bit counter of instance 1
        ws1 = 3'b011;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 5) ws1 = 3'b000;
            @(negedge clk);
            chk("sat_cnt", 68'(cnt1), 68'(i + 1 > 3 ? 3 : i + 1));
        end
        tick();

        // ASI read of way 3 with five held cycles
        asi_txn(0, 3, 34'h1_1234_5678, 34'h3_9ABC_DEF0,
                {2'b11, 2'b01, 32'h9ABC_DEF0, 32'h1234_5678}, 5);
        asi_txn(0, 1, 34'h2_0000_FFFF, 34'h0_FFFF_0000,
                {2'b00, 2'b10, 32'hFFFF_0000, 32'h0000_FFFF}, 1);

        // Reset during HOLD aborts the transaction
        tick();
        av0 = 1'b1; aw0 = 2'd2;
        tick();
        av0 = 1'b0;
        tick();
        @(negedge clk);
        chk("abort_vld_pre", 68'(dv0), 68'(1));
        rst_l = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_vld", 68'(dv0), 68'(0));
        chk("abort_data", md0, '0);
        chk("abort_rdy_low", 68'(rdy0), 68'(0));
        tick();
        rst_l = 1'b1;
        asi_txn(0, 0, 34'h3_0000_0001, 34'h2_8000_0000,
                {2'b10, 2'b11, 32'h8000_0000, 32'h0000_0001}, 2);

        // Out-of-range way on the 3-way instance returns zero
        asi_txn(1, 3, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, '0, 2);
        asi_txn(1, 2, 34'h1_0000_0003, 34'h2_0000_0005,
                {2'b10, 2'b01, 32'h0000_0005, 32'h0000_0003}, 1);

        repeat (3) tick();
        chk("q0_drained", 68'(q0.size()), 68'(0));
        chk("q1_drained", 68'(q1.size()), 68'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
